// File: rtl/count_sequencer.sv
// Job-based up/down counter: counts 0..limit or limit..0 for (reps+1) passes,
// with pause/hold, abort, end-of-pass and job-complete indications.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; Q keeps its last value
// RUN   | stepping Q one count per cycle toward the end value
// HOLD  | paused; Q frozen until pause drops
// DONE  | single-cycle completion state, returns to IDLE
module count_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       reps,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       pass_cnt;
    logic             dir_l;
    logic [WIDTH-1:0] limit_l;
    logic [1:0]       reps_l;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             at_end;

    // Job bounds come only from the latched copies so mid-job input changes are inert.
    assign start_val = dir_l ? limit_l : '0;
    assign end_val   = dir_l ? '0 : limit_l;
    assign at_end    = (Q == end_val);

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            Q        <= '0;
            pass_cnt <= '0;
            dir_l    <= 1'b0;
            limit_l  <= '0;
            reps_l   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        Q        <= dir ? limit : '0;
                        pass_cnt <= '0;
                        dir_l    <= dir;
                        limit_l  <= limit;
                        reps_l   <= reps;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (pause) begin
                        state <= HOLD;
                    end else if (!at_end) begin
                        Q <= dir_l ? (Q - WIDTH'(1)) : (Q + WIDTH'(1));
                    end else if (pass_cnt != reps_l) begin
                        // Reload straight into the next pass without a dead cycle.
                        Q        <= start_val;
                        pass_cnt <= pass_cnt + 2'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign wrap = (state == RUN) && at_end && !pause && !stop;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a job-sequence reference model.
module tb_count_sequencer;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         clear, start, dir, pause, stop;
    logic [W-1:0] limit;
    logic [1:0]   reps;
    logic [W-1:0] Q;
    logic         busy, wrap, done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .dir   (dir),
        .limit (limit),
        .reps  (reps),
        .pause (pause),
        .stop  (stop),
        .Q     (Q),
        .busy  (busy),
        .wrap  (wrap),
        .done  (done)
    );

    // Reference model: a job is the flat list of Q values it must show while counting.
    int seq[$];
    int pos  = 0;
    int plen = 1;
    int mq   = 0;
    bit act  = 0;
    bit frz  = 0;
    bit dpend = 0;

    function automatic logic [W+2:0] expv();
        bit w;
        w = act && !frz && !pause && !stop && ((pos % plen) == plen - 1);
        return {mq[W-1:0], act || dpend, dpend, w};
    endfunction

    task automatic model_edge();
        if (clear) begin
            act = 0; frz = 0; dpend = 0; mq = 0; pos = 0; plen = 1;
            seq.delete();
        end else if (dpend) begin
            dpend = 0;
        end else if (!act) begin
            if (start) begin
                seq.delete();
                plen = int'(limit) + 1;
                for (int p = 0; p <= int'(reps); p++)
                    for (int k = 0; k < plen; k++)
                        seq.push_back(dir ? int'(limit) - k : k);
                pos = 0; mq = seq[0]; act = 1; frz = 0;
            end
        end else if (stop) begin
            act = 0;
        end else if (frz) begin
            if (!pause) frz = 0;
        end else if (pause) begin
            frz = 1;
        end else if (pos == seq.size() - 1) begin
            act = 0; dpend = 1;
        end else begin
            pos++;
            mq = seq[pos];
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; start = 0; dir = 0; limit = '0; reps = '0; pause = 0; stop = 0;
    endtask

    task automatic test_reset();
        logic [W+2:0] e;
        for (int i = 0; i < 4; i++) begin
            clear = 1; start = 1'($urandom); dir = 1'($urandom); limit = W'($urandom);
            reps = 2'($urandom); pause = 1'($urandom); stop = 1'($urandom);
            #1;
            if (i > 0) begin
                e = expv(); n_total++;
                if ({Q, busy, done, wrap} !== e)
                    $display("FAIL reset cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_up_basic();
        logic [W+2:0] e;
        int nw = 0, nb = 0, nd = 0;
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            clear = (i < 2); start = (i == 2); limit = 3'd3;
            #1;
            if (i >= 2) begin
                e = expv(); n_total++;
                if ({Q, busy, done, wrap} !== e)
                    $display("FAIL up_basic cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
                else n_pass++;
                nw += int'(wrap); nb += int'(busy); nd += int'(done);
            end
            tick();
        end
        n_total++;
        if (nw != 1 || nb != 5 || nd != 1)
            $display("FAIL up_basic_counts: got wrap/busy/done=%0d/%0d/%0d required 1/5/1", nw, nb, nd);
        else n_pass++;
    endtask

    task automatic test_down_reps();
        logic [W+2:0] e;
        int nw = 0, nb = 0, nd = 0;
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            if (i == 0) begin
                start = 1; dir = 1; limit = 3'd2; reps = 2'd1;
            end else begin
                dir = 1'($urandom); limit = W'($urandom); reps = 2'($urandom);
            end
            #1;
            e = expv(); n_total++;
            if ({Q, busy, done, wrap} !== e)
                $display("FAIL down_reps cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
            else n_pass++;
            nw += int'(wrap); nb += int'(busy); nd += int'(done);
            tick();
        end
        n_total++;
        if (nw != 2 || nb != 7 || nd != 1)
            $display("FAIL down_reps_counts: got wrap/busy/done=%0d/%0d/%0d required 2/7/1", nw, nb, nd);
        else n_pass++;
    endtask

    task automatic test_pause();
        logic [W+2:0] e;
        int pc = 0, nq2 = 0, nd = 0;
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            start = (i == 0); limit = 3'd5;
            if (i > 0 && act && mq == 2 && pc < 3) begin
                pause = 1; pc++;
            end
            #1;
            e = expv(); n_total++;
            if ({Q, busy, done, wrap} !== e)
                $display("FAIL pause cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
            else n_pass++;
            if (busy && !done && Q == 3'd2) nq2++;
            nd += int'(done);
            tick();
        end
        n_total++;
        if (nq2 != 5 || nd != 1)
            $display("FAIL pause_counts: got q2_cycles/done=%0d/%0d required 5/1", nq2, nd);
        else n_pass++;
    endtask

    task automatic test_stop();
        logic [W+2:0] e;
        bit stopped = 0;
        int nd = 0;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            limit = 3'd6;
            if (i == 0) start = 1;
            else if (!stopped) start = 1'($urandom);
            if (i > 0 && act && mq == 4 && !stopped) begin
                stop = 1; stopped = 1;
            end
            #1;
            e = expv(); n_total++;
            if ({Q, busy, done, wrap} !== e)
                $display("FAIL stop cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
            else n_pass++;
            nd += int'(done);
            tick();
        end
        n_total++;
        if (nd != 0 || Q !== 3'd4 || busy !== 1'b0)
            $display("FAIL stop_final: got done_cnt/Q/busy=%0d/%0d/%b required 0/4/0", nd, Q, busy);
        else n_pass++;
    endtask

    task automatic test_clear_midjob();
        logic [W+2:0] e;
        int held = 0, nw = 0, nr = 0, nd = 0;
        bit cleared = 0;
        for (int i = 0; i < 30; i++) begin
            idle_inputs();
            if (!cleared) begin
                limit = 3'd6; start = (i == 0);
                if (i > 0 && act && mq == 3) begin
                    pause = 1; held++;
                    if (held == 3) begin
                        clear = 1; start = 1; stop = 1; cleared = 1;
                    end
                end
            end else begin
                start = !busy && nd == 0 && nr == 0;
                reps = 2'd3;
            end
            #1;
            e = expv(); n_total++;
            if ({Q, busy, done, wrap} !== e)
                $display("FAIL clear_midjob cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
            else n_pass++;
            if (cleared && !clear) begin
                nw += int'(wrap); nr += int'(busy && !done); nd += int'(done);
            end
            tick();
        end
        n_total++;
        if (nw != 4 || nr != 4 || nd != 1)
            $display("FAIL limit0_counts: got wrap/run/done=%0d/%0d/%0d required 4/4/1", nw, nr, nd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] e;
        for (int i = 0; i < 80; i++) begin
            idle_inputs();
            start = 1; dir = 1'($urandom); limit = W'($urandom_range(0, 3)); reps = 2'($urandom);
            #1;
            e = expv(); n_total++;
            if ({Q, busy, done, wrap} !== e)
                $display("FAIL back_to_back cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [W+2:0] e;
        int nd = 0;
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            dir   = 1'($urandom);
            limit = W'($urandom);
            reps  = 2'($urandom);
            pause = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            #1;
            e = expv(); n_total++;
            if ({Q, busy, done, wrap} !== e)
                $display("FAIL random cyc %0d: got Q/busy/done/wrap=%b required %b", i, {Q, busy, done, wrap}, e);
            else n_pass++;
            nd += int'(done);
            tick();
        end
        n_total++;
        if (nd == 0)
            $display("FAIL random_done_seen: got %0d done pulses required at least 1", nd);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_up_basic();
        test_down_reps();
        test_pause();
        test_stop();
        test_clear_midjob();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: WIDTH, 3, bit width of count output Q, limit input and internal comparators.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clear  input  1  reset, synchronous and active-high; sampled on rising clk edge.
REQ-004 Port: start  input  1  request a counting job; sampled only in IDLE.
REQ-005 Port: dir  input  1  job direction, 0 = up (0..limit), 1 = down (limit..0); latched on accepted start.
REQ-006 Port: limit  input  WIDTH  terminal/initial value; latched on accepted start.
REQ-007 Port: reps  input  2  passes per job minus one (passes = reps+1); latched on accepted start.
REQ-008 Port: pause  input  1  freeze counting while high.
REQ-009 Port: stop  input  1  abort current job.
REQ-010 Port: Q  output  WIDTH  registered count value.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: wrap  output  1  end-of-pass indicator.
REQ-013 Port: done  output  1  one-cycle job-complete pulse.

Function
REQ-014 FSM states SHALL be IDLE, RUN, HOLD, DONE; state, Q, pass counter and latched dir/limit/reps are registers.
REQ-015 Start value SHALL be 0 (dir=0) or limit (dir=1); end value SHALL be limit (dir=0) or 0 (dir=1).
REQ-016 IDLE: start=1 at an edge -> RUN, Q <= start value, pass counter <= 0, dir/limit/reps latched; otherwise Q holds.
REQ-017 start SHALL be ignored in RUN, HOLD, DONE; no queuing.
REQ-018 RUN, pause=0, Q != end: Q <= Q+1 (up) or Q-1 (down); no arithmetic overflow/underflow can occur since Q stays within 0..limit.
REQ-019 RUN, pause=0, Q == end, pass counter < latched reps: Q <= start value, pass counter +1, stay RUN (no dead cycle between passes).
REQ-020 RUN, pause=0, Q == end, pass counter == latched reps: -> DONE, Q holds end value.
REQ-021 RUN, pause=1: -> HOLD, Q holds; HOLD, pause=1: stay; HOLD, pause=0: -> RUN, Q unchanged at that edge.
REQ-022 stop=1 in RUN or HOLD SHALL -> IDLE, Q holds, no done pulse; stop has priority over pause and end-of-pass; stop ignored in IDLE and DONE.
REQ-023 DONE SHALL last exactly one cycle then -> IDLE; Q holds end value through IDLE until next accepted start.
REQ-024 wrap = (state==RUN) && (Q==end) && !pause && !stop, combinational from registers and those inputs.
REQ-025 done = (state==DONE), busy = (state!=IDLE), both decoded from state register only.
REQ-026 limit=0: every pass SHALL be one RUN cycle at Q=0 with wrap=1; job length = reps+1 RUN cycles.
REQ-027 Job length with no pause SHALL be (limit+1)*(reps+1) RUN cycles, then one DONE cycle.
REQ-028 Input changes to dir/limit/reps during a job SHALL have no effect on that job.

Reset
REQ-029 clear=1 at an edge SHALL force IDLE, Q=0, pass counter=0, latched dir/limit/reps=0, regardless of state or other inputs.
REQ-030 After reset busy, done, wrap SHALL be 0; clear mid-job SHALL abort without done pulse.
REQ-031 clear has priority over start, stop and pause in the same cycle.

Verification
REQ-032 clear 2 cycles, then start=1 one cycle, dir=0, limit=3, reps=0 -> Q 0,1,2,3 in RUN, wrap=1 only while Q=3, next cycle done=1 with Q=3, then busy=0.
REQ-033 dir=1, limit=2, reps=1, start -> Q 2,1,0,2,1,0, wrap high twice (both Q=0 cycles), single done pulse, 7 busy cycles total.
REQ-034 dir=0, limit=5, reps=0, pause=1 for 3 cycles when Q=2 -> Q stays 2 for those cycles, wrap=0, busy=1, resumes 3,4,5, done after Q=5.
REQ-035 stop=1 while Q=4 (limit=6, up) -> IDLE next edge, Q=4 held, done never asserted; start pulsed during the job -> ignored.
REQ-036 clear=1 mid-job (Q=3, HOLD) -> next cycle Q=0, busy=0, done=0; limit=0, reps=3, start -> 4 RUN cycles all wrap=1, Q=0, then done.
